blit_line: RTL and testbench
============================

Name: blit_line

Overview:
- Line-rasterising stage of the blitter pipeline, directly downstream of the command stage.
- Consumes the p1-stage line endpoints and run flag, and walks a Bresenham line one pixel per non-stalled cycle.
- Presents the p2-stage pixel coordinate and valid flag to the address/clip stages.
- Returns line_done to the command stage so it can retire BLIT_DRAW_LINE.

Parameters:
- COORD_W, 16, coordinate width; signed two's complement.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; all state holds while high
- p1_x1  in  COORD_W  line start x
- p1_y1  in  COORD_W  line start y
- p1_x2  in  COORD_W  line end x
- p1_y2  in  COORD_W  line end y
- p1_run_line  in  1  high while the line is being stepped
- p2_x  out  COORD_W  current pixel x (registered)
- p2_y  out  COORD_W  current pixel y (registered)
- p2_line_valid  out  1  p2_x/p2_y hold a pixel to draw
- line_done  out  1  combinational; the current pixel is the endpoint

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- Internal state:
  - cur_x, cur_y: COORD_W.
  - dx: COORD_W+1 bits, unsigned magnitude.
  - dy: COORD_W+2 bits, signed, stored negative.
  - sx, sy: 1 bit each (1 = decrement).
  - err: COORD_W+2 bits, signed.
- Stall: when stall=1, every register holds and outputs are unchanged. line_done still reflects the held state.
- Load (p1_run_line=0, !stall):
  - cur_x=p1_x1, cur_y=p1_y1.
  - dx=|p1_x2-p1_x1|, dy=-|p1_y2-p1_y1|, computed at COORD_W+1 bits so there is no overflow.
  - sx=(p1_x2<p1_x1), sy=(p1_y2<p1_y1), using signed compare.
  - err=dx+dy.
  - p2_line_valid<=0.
- The command stage holds p1 endpoints stable for one idle cycle before p1_run_line rises, so the load always captures the new line.
- Step (p1_run_line=1, !stall):
  - p2_x<=cur_x, p2_y<=cur_y, p2_line_valid<=1.
  - at_end = (cur_x==p1_x2)&&(cur_y==p1_y2).
  - If !at_end, let e2=2*err:
    - if e2>=dy: err+=dy, cur_x+=/-=1 per sx.
    - if e2<=dx: err+=dx, cur_y+=/-=1 per sy.
    - Both branches may apply in the same cycle; err receives the sum of both increments.
  - If at_end, the state holds.
- line_done = p1_run_line & at_end & !reset.
- Latency: a pixel appears on p2_* one cycle after the step cycle that produced it.
- Pixels emitted per line: max(|dx|,|dy|)+1, inclusive of both endpoints.
- Degenerate line (x1==x2, y1==y2): exactly one pixel; line_done is high on the first run cycle.
- Early drop: if p1_run_line falls before at_end (command aborted), the block reloads next cycle. No partial state survives.
- Coordinate arithmetic wraps modulo 2^COORD_W. Endpoints beyond ±2^(COORD_W-1) are undefined.
- Reset (including mid-line): p2_x=0, p2_y=0, p2_line_valid=0, cur_x=cur_y=0, err=0, dx=dy=0, sx=sy=0. Reset overrides stall.

Optional Feature:
- Macro: BLIT_LINE_CLIP_EN.
- When defined:
  - Adds inputs clip_x1, clip_y1, clip_x2, clip_y2 (COORD_W each, inclusive bounds).
  - During a step, p2_line_valid<=1 only if clip_x1<=cur_x<=clip_x2 and clip_y1<=cur_y<=clip_y2 (signed compares).
  - Stepping and line_done are unaffected, so clipped pixels still consume cycles.
- When undefined: no clip ports; every stepped pixel is valid. Downstream clipping handles bounds.

Test Plan:
- Horizontal: load (0,0)->(3,0), then run -> p2 shows (0,0),(1,0),(2,0),(3,0) on consecutive cycles; line_done high only on the 4th run cycle.
- Shallow: (0,0)->(4,2) -> pixels (0,0),(1,1),(2,1),(3,2),(4,2); line_done on the 5th run cycle.
- Negative diagonal: (3,3)->(0,0) -> (3,3),(2,2),(1,1),(0,0); sx=sy=1.
- Single point: (5,5)->(5,5) -> one pixel (5,5); line_done on the first run cycle; the next cycle with p1_run_line=0 gives p2_line_valid=0.
- Stall: (0,0)->(3,0) with stall high for 2 cycles after pixel (1,0) -> p2 holds (1,0) for 3 cycles, then (2,0),(3,0); no pixel is skipped or repeated after release.
- Reset mid-line: assert reset after the 2nd pixel of (0,0)->(10,0) -> next edge p2_line_valid=0, p2_x=p2_y=0, line_done=0; a following load of (7,1)->(8,1) yields exactly (7,1),(8,1). With BLIT_LINE_CLIP_EN and clip (1,0)-(2,0) on (0,0)->(3,0): valid only for (1,0),(2,0); line_done still on the 4th cycle.

Source files
------------

// File: rtl/blit_line_if.sv
// blit_line_if: groups the command-stage line request and the p2 pixel result of the
// line rasteriser into one bundle.
//   master : command/test side; drives stall, p1_* endpoints, p1_run_line (and clip bounds)
//   slave  : blit_line; drives p2_x, p2_y, p2_line_valid, line_done
// Optional: BLIT_LINE_CLIP_EN adds clip_x1/clip_y1/clip_x2/clip_y2 (inclusive bounds).
interface blit_line_if #(
  parameter int COORD_W = 16
);
  logic                      stall;
  logic signed [COORD_W-1:0] p1_x1;
  logic signed [COORD_W-1:0] p1_y1;
  logic signed [COORD_W-1:0] p1_x2;
  logic signed [COORD_W-1:0] p1_y2;
  logic                      p1_run_line;
  logic signed [COORD_W-1:0] p2_x;
  logic signed [COORD_W-1:0] p2_y;
  logic                      p2_line_valid;
  logic                      line_done;
`ifdef BLIT_LINE_CLIP_EN
  logic signed [COORD_W-1:0] clip_x1;
  logic signed [COORD_W-1:0] clip_y1;
  logic signed [COORD_W-1:0] clip_x2;
  logic signed [COORD_W-1:0] clip_y2;

  modport master (
    output stall, p1_x1, p1_y1, p1_x2, p1_y2, p1_run_line,
    output clip_x1, clip_y1, clip_x2, clip_y2,
    input  p2_x, p2_y, p2_line_valid, line_done
  );
  modport slave (
    input  stall, p1_x1, p1_y1, p1_x2, p1_y2, p1_run_line,
    input  clip_x1, clip_y1, clip_x2, clip_y2,
    output p2_x, p2_y, p2_line_valid, line_done
  );
`else
  modport master (
    output stall, p1_x1, p1_y1, p1_x2, p1_y2, p1_run_line,
    input  p2_x, p2_y, p2_line_valid, line_done
  );
  modport slave (
    input  stall, p1_x1, p1_y1, p1_x2, p1_y2, p1_run_line,
    output p2_x, p2_y, p2_line_valid, line_done
  );
`endif
endinterface

// File: rtl/blit_line.sv
// blit_line: Bresenham line rasteriser of the blitter pipeline. While p1_run_line is low it
// loads the p1 endpoints; while high it walks the line one pixel per non-stalled cycle and
// presents each pixel on the registered p2 outputs one cycle later.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high reset (overrides stall)
//   bus   : blit_line_if.slave (stall, p1_* endpoints/run in; p2_* pixel, line_done out)
// Optional: BLIT_LINE_CLIP_EN gates p2_line_valid with the clip window; stepping and
// line_done are unaffected by clipping.
module blit_line #(
  parameter int COORD_W = 16
) (
  input logic         clock,
  input logic         reset,
  blit_line_if.slave  bus
);
  localparam int DW  = COORD_W + 1;  // |delta| magnitude
  localparam int EW  = COORD_W + 2;  // err / negative dy
  localparam int E2W = COORD_W + 3;  // 2*err
  localparam logic [COORD_W-1:0] One = COORD_W'(1);

  logic signed [COORD_W-1:0] r_cur_x, r_cur_y;
  logic        [DW-1:0]      r_dx;
  logic signed [EW-1:0]      r_dy;
  logic signed [EW-1:0]      r_err;
  logic                      r_sx, r_sy;
  logic signed [COORD_W-1:0] r_p2_x, r_p2_y;
  logic                      r_p2_valid;

  // Load-side deltas, widened by one bit so the subtraction cannot overflow.
  logic signed [DW-1:0] w_ddx, w_ddy;
  logic        [DW-1:0] w_adx, w_ady;
  logic signed [EW-1:0] w_dy_load, w_err_load;
  logic                 w_sx_load, w_sy_load;

  assign w_ddx      = {bus.p1_x2[COORD_W-1], bus.p1_x2} - {bus.p1_x1[COORD_W-1], bus.p1_x1};
  assign w_ddy      = {bus.p1_y2[COORD_W-1], bus.p1_y2} - {bus.p1_y1[COORD_W-1], bus.p1_y1};
  assign w_adx      = w_ddx[DW-1] ? -w_ddx : w_ddx;
  assign w_ady      = w_ddy[DW-1] ? -w_ddy : w_ddy;
  assign w_dy_load  = -$signed({1'b0, w_ady});
  assign w_err_load = $signed({1'b0, w_adx}) + w_dy_load;
  assign w_sx_load  = bus.p1_x2 < bus.p1_x1;
  assign w_sy_load  = bus.p1_y2 < bus.p1_y1;

  // Step-side decisions.
  logic                 w_at_end;
  logic signed [E2W-1:0] w_e2, w_dy_ext, w_dx_ext;
  logic                 w_step_x, w_step_y;
  logic signed [EW-1:0] w_inc_x, w_inc_y, w_err_next;
  logic                 w_in_clip;

  assign w_at_end   = (r_cur_x == bus.p1_x2) && (r_cur_y == bus.p1_y2);
  assign w_e2       = {r_err, 1'b0};
  assign w_dy_ext   = {r_dy[EW-1], r_dy};
  assign w_dx_ext   = {2'b00, r_dx};
  assign w_step_x   = w_e2 >= w_dy_ext;
  assign w_step_y   = w_e2 <= w_dx_ext;
  // Both axes may step in one cycle; err takes the sum of both increments.
  assign w_inc_x    = w_step_x ? r_dy : '0;
  assign w_inc_y    = w_step_y ? $signed({1'b0, r_dx}) : '0;
  assign w_err_next = r_err + w_inc_x + w_inc_y;

`ifdef BLIT_LINE_CLIP_EN
  assign w_in_clip = (r_cur_x >= bus.clip_x1) && (r_cur_x <= bus.clip_x2) &&
                     (r_cur_y >= bus.clip_y1) && (r_cur_y <= bus.clip_y2);
`else
  assign w_in_clip = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_err      <= '0;
      r_sx       <= 1'b0;
      r_sy       <= 1'b0;
      r_p2_x     <= '0;
      r_p2_y     <= '0;
      r_p2_valid <= 1'b0;
    end else if (!bus.stall) begin
      if (!bus.p1_run_line) begin
        // Idle: (re)load, so an aborted line leaves nothing behind.
        r_cur_x    <= bus.p1_x1;
        r_cur_y    <= bus.p1_y1;
        r_dx       <= w_adx;
        r_dy       <= w_dy_load;
        r_err      <= w_err_load;
        r_sx       <= w_sx_load;
        r_sy       <= w_sy_load;
        r_p2_valid <= 1'b0;
      end else begin
        r_p2_x     <= r_cur_x;
        r_p2_y     <= r_cur_y;
        r_p2_valid <= w_in_clip;
        if (!w_at_end) begin
          if (w_step_x) r_cur_x <= r_sx ? r_cur_x - One : r_cur_x + One;
          if (w_step_y) r_cur_y <= r_sy ? r_cur_y - One : r_cur_y + One;
          r_err <= w_err_next;
        end
      end
    end
  end

  assign bus.p2_x          = r_p2_x;
  assign bus.p2_y          = r_p2_y;
  assign bus.p2_line_valid = r_p2_valid;
  assign bus.line_done     = bus.p1_run_line & w_at_end & ~reset;

endmodule

// File: tb/tb_blit_line.sv
// tb_blit_line: self-checking bench for blit_line. Expected pixel sequences come either from
// hand-written lists or from an integer Bresenham model; expected p2 outputs are tracked as
// the pixel stream delayed by one non-stalled cycle.
module tb_blit_line;
  localparam int COORD_W = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  blit_line_if #(.COORD_W(COORD_W)) bus ();

  blit_line #(.COORD_W(COORD_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected registered p2 outputs.
  logic                      exp_v;
  logic signed [COORD_W-1:0] exp_x, exp_y;

  int px[$];
  int py[$];
  bit stall_q[$];
  int stall_pct = 0;

  int clx1 = -32768, cly1 = -32768, clx2 = 32767, cly2 = 32767;

  function automatic bit in_clip(input int x, input int y);
    return (x >= clx1) && (x <= clx2) && (y >= cly1) && (y <= cly2);
  endfunction

  task automatic apply_clip();
`ifdef BLIT_LINE_CLIP_EN
    bus.clip_x1 = COORD_W'(clx1);
    bus.clip_y1 = COORD_W'(cly1);
    bus.clip_x2 = COORD_W'(clx2);
    bus.clip_y2 = COORD_W'(cly2);
`endif
  endtask

  // Integer reference: list of pixels from (x1,y1) to (x2,y2) inclusive.
  task automatic model_line(input int x1, input int y1, input int x2, input int y2);
    int dx, dy, sx, sy, err, e2, x, y;
    px.delete();
    py.delete();
    dx  = (x2 > x1) ? x2 - x1 : x1 - x2;
    dy  = (y2 > y1) ? y1 - y2 : y2 - y1;
    sx  = (x1 < x2) ? 1 : -1;
    sy  = (y1 < y2) ? 1 : -1;
    err = dx + dy;
    x   = x1;
    y   = y1;
    for (int n = 0; n < 100000; n++) begin
      px.push_back(x);
      py.push_back(y);
      if (x == x2 && y == y2) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // One clock: drive, check at negedge, then advance to just after the posedge.
  task automatic step_cycle(input bit run, input bit st, input bit exp_done, input string tag);
    bus.p1_run_line = run;
    bus.stall       = st;
    @(negedge clock);
    checks++;
    if (bus.line_done !== exp_done) begin
      errors++;
      $display("FAIL %s line_done: got %0b expected %0b", tag, bus.line_done, exp_done);
    end
    checks++;
    if (bus.p2_line_valid !== exp_v || bus.p2_x !== exp_x || bus.p2_y !== exp_y) begin
      errors++;
      $display("FAIL %s p2: got v=%0b (%0d,%0d) expected v=%0b (%0d,%0d)", tag,
               bus.p2_line_valid, bus.p2_x, bus.p2_y, exp_v, exp_x, exp_y);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic load_cycle(input int x1, input int y1, input int x2, input int y2,
                            input string tag);
    bus.p1_x1 = COORD_W'(x1);
    bus.p1_y1 = COORD_W'(y1);
    bus.p1_x2 = COORD_W'(x2);
    bus.p1_y2 = COORD_W'(y2);
    step_cycle(1'b0, 1'b0, 1'b0, tag);
    exp_v = 1'b0;
  endtask

  // Loads a line then steps it to completion against the px/py expectation.
  task automatic run_line(input int x1, input int y1, input int x2, input int y2,
                          input string tag);
    int  k, n, guard;
    bit  st;
    load_cycle(x1, y1, x2, y2, tag);
    n     = px.size();
    k     = 0;
    guard = 0;
    while (k < n && guard < 4 * n + 20) begin
      if (stall_q.size() > 0) st = stall_q.pop_front();
      else st = ($urandom_range(99) < stall_pct);
      step_cycle(1'b1, st, (k == n - 1), tag);
      if (!st) begin
        exp_v = in_clip(px[k], py[k]);
        exp_x = COORD_W'(px[k]);
        exp_y = COORD_W'(py[k]);
        k++;
      end
      guard++;
    end
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL %s cycle budget: stepped %0d expected %0d", tag, k, n);
    end
  endtask

  task automatic set_list(input int xs[$], input int ys[$]);
    px = xs;
    py = ys;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.p1_x1 = '0; bus.p1_y1 = '0; bus.p1_x2 = '0; bus.p1_y2 = '0;
    bus.p1_run_line = 1'b0;
    bus.stall = 1'b0;
    @(posedge clock);
    #1;
    exp_v = 1'b0; exp_x = '0; exp_y = '0;
    // At-end state with run high: reset must still mask line_done.
    step_cycle(1'b1, 1'b0, 1'b0, "reset");
    step_cycle(1'b1, 1'b1, 1'b0, "reset_over_stall");
    reset = 1'b0;
  endtask

  task automatic test_directed();
    stall_pct = 0;
    set_list('{0, 1, 2, 3}, '{0, 0, 0, 0});
    run_line(0, 0, 3, 0, "horizontal");
    set_list('{0, 1, 2, 3, 4}, '{0, 1, 1, 2, 2});
    run_line(0, 0, 4, 2, "shallow");
    set_list('{3, 2, 1, 0}, '{3, 2, 1, 0});
    run_line(3, 3, 0, 0, "neg_diag");
    set_list('{5}, '{5});
    run_line(5, 5, 5, 5, "single");
    step_cycle(1'b0, 1'b0, 1'b0, "single_idle");
    exp_v = 1'b0;
    step_cycle(1'b0, 1'b0, 1'b0, "single_idle2");
  endtask

  task automatic test_stall();
    stall_pct = 0;
    stall_q = '{0, 0, 1, 1};
    set_list('{0, 1, 2, 3}, '{0, 0, 0, 0});
    run_line(0, 0, 3, 0, "stall");
  endtask

  task automatic test_reset_midline();
    stall_pct = 0;
    load_cycle(0, 0, 10, 0, "midreset_load");
    step_cycle(1'b1, 1'b0, 1'b0, "midreset_s0");
    exp_v = 1'b1; exp_x = 0; exp_y = 0;
    step_cycle(1'b1, 1'b0, 1'b0, "midreset_s1");
    exp_v = 1'b1; exp_x = 1; exp_y = 0;
    reset = 1'b1;
    step_cycle(1'b1, 1'b0, 1'b0, "midreset_assert");
    exp_v = 1'b0; exp_x = '0; exp_y = '0;
    step_cycle(1'b1, 1'b0, 1'b0, "midreset_held");
    reset = 1'b0;
    set_list('{7, 8}, '{1, 1});
    run_line(7, 1, 8, 1, "after_reset");
  endtask

  task automatic test_clip();
`ifdef BLIT_LINE_CLIP_EN
    stall_pct = 0;
    clx1 = 1; cly1 = 0; clx2 = 2; cly2 = 0;
    apply_clip();
    set_list('{0, 1, 2, 3}, '{0, 0, 0, 0});
    run_line(0, 0, 3, 0, "clip");
    clx1 = -32768; cly1 = -32768; clx2 = 32767; cly2 = 32767;
    apply_clip();
`endif
  endtask

  task automatic test_random();
    int x1, y1, x2, y2, bx, by;
    stall_pct = 20;
    for (int i = 0; i < 25; i++) begin
      bx = (i % 2 == 0) ? 0 : int'($urandom_range(40000)) - 20000;
      by = (i % 2 == 0) ? 0 : int'($urandom_range(40000)) - 20000;
      x1 = bx + int'($urandom_range(60)) - 30;
      y1 = by + int'($urandom_range(60)) - 30;
      x2 = bx + int'($urandom_range(60)) - 30;
      y2 = by + int'($urandom_range(60)) - 30;
      model_line(x1, y1, x2, y2);
      run_line(x1, y1, x2, y2, "random");
    end
    stall_pct = 0;
  endtask

  task automatic test_back_to_back();
    stall_pct = 0;
    set_list('{-2, -1, 0}, '{1, 0, -1});
    run_line(-2, 1, 0, -1, "b2b_a");
    set_list('{0, 0, 0}, '{-1, -2, -3});
    run_line(0, -1, 0, -3, "b2b_b");
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_clip();
    test_reset();
    test_directed();
    test_stall();
    test_reset_midline();
    test_clip();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
